// File: rtl/multi_key_debounce.sv
// Multi-channel key debouncer.
// Every channel runs on its own: a 2-FF synchroniser, optional polarity
// inversion, then a counter debounce. Each channel produces a debounced level,
// registered press and release pulses, and long-press auto-repeat pulses.
// All outputs are plain registered signals in the clk domain.
module multi_key_debounce #(
   parameter int NUM_KEYS   = 5,
   parameter int CNT_W      = 20,
   parameter int CNT_MAX    = 9,
   parameter int ACTIVE_LOW = 0,
   parameter int HOLD_MAX   = 50,
   parameter int REPEAT_MAX = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   input  logic                repeat_en,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                any_press
);

   localparam logic             POL      = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_MAX);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [NUM_KEYS-1:0]            norm;
   logic [NUM_KEYS-1:0]            sync1;
   logic [NUM_KEYS-1:0]            sync2;
   logic [NUM_KEYS-1:0]            stable;
   logic [NUM_KEYS-1:0]            stable_nxt;
   logic [NUM_KEYS-1:0]            stable_d;
   logic [NUM_KEYS-1:0][CNT_W-1:0] cnt;
   logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_nxt;
   logic [NUM_KEYS-1:0][CNT_W-1:0] hcnt;
   logic [NUM_KEYS-1:0][CNT_W-1:0] hcnt_nxt;
   logic [NUM_KEYS-1:0]            ph;
   logic [NUM_KEYS-1:0]            ph_nxt;
   logic [NUM_KEYS-1:0]            press_nxt;
   logic [NUM_KEYS-1:0]            release_nxt;
   logic [NUM_KEYS-1:0]            repeat_nxt;

   // Normalise polarity so everything downstream treats 1 as "pressed".
   assign norm      = key_in ^ {NUM_KEYS{POL}};
   assign key_level = stable;

   // Two-flop synchroniser for the asynchronous raw inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= norm;
         sync2 <= sync1;
      end
   end

   // Debounce: accept a new level after CNT_MAX+1 consecutive differing samples.
   always_comb begin
      stable_nxt = stable;
      cnt_nxt    = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_LIM) begin
               stable_nxt[i] = sync2[i];
               cnt_nxt[i]    = '0;
            end else begin
               cnt_nxt[i] = cnt[i] + ONE;
            end
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable   <= '0;
         stable_d <= '0;
         cnt      <= '0;
      end else begin
         stable   <= stable_nxt;
         stable_d <= stable;
         cnt      <= cnt_nxt;
      end
   end

   // Edge detection on the debounced level, one cycle after the level moves.
   always_comb begin
      press_nxt   = stable & ~stable_d;
      release_nxt = ~stable & stable_d;
   end

   // Auto-repeat: hold phase counts to HOLD_MAX, then repeat phase counts to
   // REPEAT_MAX. The counter restarts at 1 on a pulse so the spacing between
   // successive pulses equals the limit. A pulse is suppressed if the level is
   // about to fall, so no repeat appears in the cycle the key is released.
   always_comb begin
      hcnt_nxt   = hcnt;
      ph_nxt     = ph;
      repeat_nxt = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (!stable[i] || !repeat_en) begin
            hcnt_nxt[i] = '0;
            ph_nxt[i]   = 1'b0;
         end else if (!ph[i] && (hcnt[i] == HOLD_LIM)) begin
            repeat_nxt[i] = stable_nxt[i];
            ph_nxt[i]     = 1'b1;
            hcnt_nxt[i]   = ONE;
         end else if (ph[i] && (hcnt[i] == REP_LIM)) begin
            repeat_nxt[i] = stable_nxt[i];
            hcnt_nxt[i]   = ONE;
         end else begin
            hcnt_nxt[i] = hcnt[i] + ONE;
         end
      end
   end

   // Hold/repeat state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         ph   <= '0;
      end else begin
         hcnt <= hcnt_nxt;
         ph   <= ph_nxt;
      end
   end

   // Registered output pulses; any_press is aligned with key_press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_press   <= '0;
         key_release <= '0;
         key_repeat  <= '0;
         any_press   <= 1'b0;
      end else begin
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_repeat  <= repeat_nxt;
         any_press   <= |press_nxt;
      end
   end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench for multi_key_debounce: default-parameter instance plus an
// ACTIVE_LOW instance, with expected latencies worked out by hand.
module tb_multi_key_debounce;

   localparam int NK = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] key_in = '0;
   logic [NK-1:0] key_al = '1;
   logic          repeat_en = 1'b0;

   logic [NK-1:0] key_level, key_press, key_release, key_repeat;
   logic          any_press;
   logic [NK-1:0] level_al, press_al, release_al, repeat_al;
   logic          any_al;

   int errors = 0;
   int checks = 0;
   int edge_n = 0;
   int base;

   int npress [NK];
   int nrel   [NK];
   int nrep   [NK];
   int nlvl   [NK];
   int press_edge [NK];
   int rel_edge   [NK];
   int first_rep  [NK];
   int last_rep   [NK];
   int gap_err, coinc, any_bad, nany;

   multi_key_debounce dut (
      .clk(clk), .rst(rst), .key_in(key_in), .repeat_en(repeat_en),
      .key_level(key_level), .key_press(key_press), .key_release(key_release),
      .key_repeat(key_repeat), .any_press(any_press)
   );

   multi_key_debounce #(.ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .key_in(key_al), .repeat_en(repeat_en),
      .key_level(level_al), .key_press(press_al), .key_release(release_al),
      .key_repeat(repeat_al), .any_press(any_al)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NK; c++) begin
         npress[c] = 0; nrel[c] = 0; nrep[c] = 0; nlvl[c] = 0;
         press_edge[c] = -1; rel_edge[c] = -1; first_rep[c] = -1; last_rep[c] = -1;
      end
      gap_err = 0; coinc = 0; any_bad = 0; nany = 0;
   endtask

   // Advance one clock and log the events seen on the default instance.
   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
      for (int c = 0; c < NK; c++) begin
         if (key_level[c]) nlvl[c]++;
         if (key_press[c]) begin
            npress[c]++;
            press_edge[c] = edge_n;
            if (key_repeat[c]) coinc++;
         end
         if (key_release[c]) begin
            nrel[c]++;
            rel_edge[c] = edge_n;
         end
         if (key_repeat[c]) begin
            if (nrep[c] == 0) first_rep[c] = edge_n;
            else if (edge_n - last_rep[c] != 20) gap_err++;
            last_rep[c] = edge_n;
            nrep[c]++;
         end
      end
      if (any_press !== (|key_press)) any_bad++;
      if (any_press) nany++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   function automatic int sum(input int a [NK]);
      int s = 0;
      for (int c = 0; c < NK; c++) s += a[c];
      return s;
   endfunction

   initial begin
      clear_counts();
      // Reset state
      ticks(3);
      chk("reset_outputs", {key_level, key_press, key_release, key_repeat, any_press}, 0);
      chk("reset_outputs_al", {level_al, press_al, release_al, repeat_al, any_al}, 0);
      rst = 1'b0;
      ticks(3);
      chk("idle_level", key_level, 0);
      chk("idle_level_al", level_al, 0);

      // Clean press and release on channel 0, repeat disabled
      clear_counts();
      key_in = 5'b00001;
      ticks(11);
      chk("press_level_e11", key_level[0], 0);
      tick();
      chk("press_level_e12", key_level[0], 1);
      chk("press_pulse_e12", key_press[0], 0);
      tick();
      chk("press_pulse_e13", key_press[0], 1);
      chk("any_press_e13", any_press, 1);
      tick();
      chk("press_pulse_e14", key_press[0], 0);
      chk("any_press_e14", any_press, 0);
      ticks(26);
      key_in = 5'b00000;
      ticks(11);
      chk("rel_level_e11", key_level[0], 1);
      tick();
      chk("rel_level_e12", key_level[0], 0);
      tick();
      chk("rel_pulse_e13", key_release[0], 1);
      tick();
      chk("rel_pulse_e14", key_release[0], 0);
      ticks(5);
      chk("clean_npress", npress[0], 1);
      chk("clean_nrel", nrel[0], 1);
      chk("clean_nrep", sum(nrep), 0);
      chk("clean_any_consistent", any_bad, 0);

      // Bounce on channel 1: 4-cycle runs never reach the threshold
      clear_counts();
      for (int k = 0; k < 10; k++) begin
         key_in = (k % 2 == 0) ? 5'b00010 : 5'b00000;
         ticks(4);
      end
      key_in = 5'b00000;
      ticks(20);
      chk("bounce_level", nlvl[1], 0);
      chk("bounce_press", sum(npress), 0);
      chk("bounce_release", sum(nrel), 0);
      chk("bounce_repeat", sum(nrep), 0);
      chk("bounce_any", nany, 0);

      // Long hold on channel 2 with repeat enabled
      clear_counts();
      repeat_en = 1'b1;
      base = edge_n;
      key_in = 5'b00100;
      ticks(200);
      key_in = 5'b00000;
      ticks(60);
      chk("hold_npress", npress[2], 1);
      chk("hold_press_edge", press_edge[2] - base, 13);
      chk("hold_first_rep_gap", first_rep[2] - press_edge[2], 50);
      chk("hold_nrep", nrep[2], 8);
      chk("hold_last_rep", last_rep[2] - base, 203);
      chk("hold_rep_spacing", gap_err, 0);
      chk("hold_press_rep_coinc", coinc, 0);
      chk("hold_rel_edge", rel_edge[2] - base, 213);
      chk("hold_other_rep", sum(nrep) - nrep[2], 0);

      // Same hold with repeat disabled, enabled after 100 cycles
      clear_counts();
      repeat_en = 1'b0;
      base = edge_n;
      key_in = 5'b00100;
      ticks(100);
      chk("noen_nrep", nrep[2], 0);
      repeat_en = 1'b1;
      ticks(100);
      key_in = 5'b00000;
      ticks(40);
      // First edge that samples repeat_en high is base+101; first pulse 50 later.
      chk("late_en_first_rep", first_rep[2] - base, 151);
      chk("late_en_nrep", nrep[2], 4);
      chk("late_en_spacing", gap_err, 0);
      chk("late_en_nrel", nrel[2], 1);

      // Reset in the middle of a debounce count
      clear_counts();
      key_in = 5'b01000;
      ticks(7);
      rst = 1'b1;
      #1;
      chk("rst_mid_deb_out", {key_level, key_press, key_release, key_repeat, any_press}, 0);
      ticks(2);
      rst = 1'b0;
      ticks(11);
      chk("rst_deb_level_e11", key_level[3], 0);
      tick();
      chk("rst_deb_level_e12", key_level[3], 1);
      tick();
      chk("rst_deb_press_e13", key_press[3], 1);

      // Reset during a hold: progress discarded, no pulses on deassert
      ticks(30);
      rst = 1'b1;
      #1;
      chk("rst_hold_out", {key_level, key_press, key_release, key_repeat, any_press}, 0);
      ticks(2);
      clear_counts();
      rst = 1'b0;
      ticks(12);
      chk("rst_hold_no_pulse", sum(npress) + sum(nrel) + sum(nrep), 0);
      chk("rst_hold_level_e12", key_level[3], 1);
      tick();
      chk("rst_hold_press_e13", key_press[3], 1);
      ticks(55);
      chk("rst_hold_nrep", nrep[3], 1);
      chk("rst_hold_first_rep", first_rep[3] - press_edge[3], 50);
      key_in = 5'b00000;
      repeat_en = 1'b0;
      ticks(20);

      // Active-low instance: channels 0 and 4 pressed together
      chk("al_idle", {level_al, press_al, release_al, repeat_al, any_al}, 0);
      key_al = 5'b01110;
      ticks(12);
      chk("al_level_e12", level_al, 5'b10001);
      chk("al_press_e12", press_al, 0);
      tick();
      chk("al_press_e13", press_al, 5'b10001);
      chk("al_any_e13", any_al, 1);
      tick();
      chk("al_press_e14", press_al, 0);
      chk("al_any_e14", any_al, 0);
      key_al = 5'b11111;
      ticks(13);
      chk("al_release_e13", release_al, 5'b10001);
      chk("al_level_rel", level_al, 0);
      ticks(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
